// File: rtl/collatz_sweep_if.sv
// Bundle of sweep control, iterator handshake and result FIFO signals.
// master is the sweep engine, slave is the surrounding environment.
interface collatz_sweep_if;
  logic        start;
  logic [31:0] base;
  logic [7:0]  count;
  logic        busy;

  logic        coll_go;
  logic [31:0] coll_n;
  logic [31:0] coll_dout;
  logic        coll_done;

  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_n;
  logic [15:0] res_steps;
  logic [31:0] res_peak;
  logic        res_timeout;

  modport master (
    input  start, base, count, coll_dout, coll_done, res_ready,
    output busy, coll_go, coll_n, res_valid, res_n, res_steps, res_peak, res_timeout
  );

  modport slave (
    output start, base, count, coll_dout, coll_done, res_ready,
    input  busy, coll_go, coll_n, res_valid, res_n, res_steps, res_peak, res_timeout
  );
endinterface

// File: rtl/collatz_sweep.sv
// Sweeps consecutive Collatz start values through an external iterator and
// queues {n, steps, peak, timeout} results in a small FIFO.
module collatz_sweep #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned MAX_STEPS = 1000
) (
  input logic             clk,
  input logic             rst_n,
  collatz_sweep_if.master bus
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [15:0] MaxSteps = 16'(MAX_STEPS);
  localparam logic [AW:0] FullOcc  = (AW + 1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two, at least 2");
  end
  if (MAX_STEPS < 1 || MAX_STEPS > 65535) begin : g_bad_steps
    $error("MAX_STEPS must lie in 1..65535");
  end

  typedef enum logic [2:0] {StIdle, StIssue, StBlank, StRun, StWrite} state_e;

  typedef struct packed {
    logic [31:0] n;
    logic [15:0] steps;
    logic [31:0] peak;
    logic        timeout;
  } entry_t;

  state_e      state_q;
  logic [31:0] cur_q;
  logic [7:0]  remaining_q;
  logic [15:0] counter_q;
  logic [31:0] peak_q;
  logic [15:0] steps_q;
  logic        timeout_q;
  logic        busy_q;
  logic        go_q;

  logic [AW:0] wptr_q, rptr_q;
  logic [AW:0] occ;
  logic        full, push, pop;
  entry_t      mem_q [DEPTH];
  entry_t      head;
  logic [31:0] peak_max;

  assign occ      = wptr_q - rptr_q;
  assign full     = (occ == FullOcc);
  // Occupancy is taken before any same-cycle pop, so a full FIFO delays the push.
  assign push     = (state_q == StWrite) && !full;
  assign pop      = bus.res_valid && bus.res_ready;
  assign peak_max = (bus.coll_dout > peak_q) ? bus.coll_dout : peak_q;
  assign head     = mem_q[rptr_q[AW-1:0]];

  assign bus.busy        = busy_q;
  assign bus.coll_go     = go_q;
  assign bus.coll_n      = cur_q;
  assign bus.res_valid   = (wptr_q != rptr_q);
  assign bus.res_n       = head.n;
  assign bus.res_steps   = head.steps;
  assign bus.res_peak    = head.peak;
  assign bus.res_timeout = head.timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cur_q       <= '0;
      remaining_q <= '0;
      counter_q   <= '0;
      peak_q      <= '0;
      steps_q     <= '0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
      go_q        <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start && bus.count != 8'd0) begin
            cur_q       <= bus.base;
            remaining_q <= bus.count;
            state_q     <= StIssue;
            go_q        <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        StIssue: begin
          go_q    <= 1'b0;
          state_q <= StBlank;
        end
        // Iterator outputs still belong to the previous value here.
        StBlank: begin
          counter_q <= '0;
          peak_q    <= '0;
          state_q   <= StRun;
        end
        StRun: begin
          peak_q <= peak_max;
          if (bus.coll_done) begin
            steps_q   <= counter_q;
            timeout_q <= 1'b0;
            state_q   <= StWrite;
          end else if (counter_q == MaxSteps) begin
            steps_q   <= MaxSteps;
            timeout_q <= 1'b1;
            state_q   <= StWrite;
          end else begin
            counter_q <= counter_q + 16'd1;
          end
        end
        StWrite: begin
          if (push) begin
            remaining_q <= remaining_q - 8'd1;
            cur_q       <= cur_q + 32'd1;
            if (remaining_q != 8'd1) begin
              state_q <= StIssue;
              go_q    <= 1'b1;
            end else begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          go_q    <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage needs no reset: entries are only visible between the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q[AW-1:0]] <= '{n: cur_q, steps: steps_q, peak: peak_q, timeout: timeout_q};
    end
  end

endmodule
